// File: rtl/spram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: combinational grant,
// fair alternation on ties, bounded lock bursts and registered read-return strobes.
module spram_arbiter #(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 8,
    parameter int unsigned max_burst  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  b_req,
    input  logic                  a_lock,
    input  logic                  b_lock,
    input  logic                  a_we,
    input  logic                  b_we,
    input  logic [addr_width-1:0] a_addr,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] a_wdata,
    input  logic [data_width-1:0] b_wdata,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [data_width-1:0] rdata,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_data,
    output logic                  ram_we,
    input  logic [data_width-1:0] ram_q
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(max_burst);
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        LOCKED
    } state_t;

    state_t             state, state_nxt;
    logic               last, last_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic               keep_owner;
    logic               win_b;
    logic               gnt_any;

    // Arbitration, RAM mux and next-state; everything is forced idle while in reset.
    always_comb begin
        a_gnt         = 1'b0;
        b_gnt         = 1'b0;
        keep_owner    = 1'b0;
        win_b         = 1'b0;
        gnt_any       = 1'b0;
        state_nxt     = IDLE;
        last_nxt      = last;
        burst_cnt_nxt = '0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_data      = '0;

        if (rst_n) begin
            if (a_req && b_req) begin
                keep_owner = (state == LOCKED) && (burst_cnt < BURST_LIM);
                win_b      = keep_owner ? last : ~last;
            end else begin
                win_b      = b_req;
            end
            gnt_any = a_req || b_req;
            a_gnt   = gnt_any && (win_b == SEL_A);
            b_gnt   = gnt_any && (win_b == SEL_B);
        end

        if (gnt_any) begin
            last_nxt = win_b;
            if ((state == LOCKED) && (win_b == last)) begin
                burst_cnt_nxt = (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_W'(1);
            end else begin
                burst_cnt_nxt = CNT_W'(1);
            end
            state_nxt = (win_b ? b_lock : a_lock) ? LOCKED : SERVE;
            ram_we    = win_b ? b_we    : a_we;
            ram_addr  = win_b ? b_addr  : a_addr;
            ram_data  = win_b ? b_wdata : a_wdata;
        end
    end

    // State register; last resets to B so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= SEL_B;
            burst_cnt <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_cnt_nxt;
            a_rvalid  <= a_gnt && !a_we;
            b_rvalid  <= b_gnt && !b_we;
        end
    end

    assign rdata = ram_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural arbitration/RAM model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spram_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, b_req, a_lock, b_lock, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    int n_cmp = 0;
    int n_bad = 0;

    spram_arbiter #(.addr_width(AW), .data_width(DW), .max_burst(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .b_req(b_req), .a_lock(a_lock), .b_lock(b_lock),
        .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr),
        .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write at the edge, read data registered one cycle later.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: who was served last, how long the current locked run is,
    // whether the last grant asked for a lock, and the read pending for next cycle.
    logic [DW-1:0] shadow [256];
    logic          m_last;
    int            m_run;
    logic          m_prev_locked;
    logic          m_rv_a, m_rv_b;
    logic [DW-1:0] m_rd;
    logic          e_b_win, e_gnt, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    logic          s_a_gnt, s_b_gnt, s_a_rv, s_b_rv, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_rdata;
    logic [7:0]    s_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_a_gnt", 32'(a_gnt), 32'd0);
            chk("rst_b_gnt", 32'(b_gnt), 32'd0);
            chk("rst_ram_we", 32'(ram_we), 32'd0);
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_ram_data", 32'(ram_data), 32'd0);
            chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
            chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
            chk("rst_burst_cnt", 32'(dut.burst_cnt), 32'd0);
            m_last        = 1'b1;
            m_run         = 0;
            m_prev_locked = 1'b0;
            m_rv_a        = 1'b0;
            m_rv_b        = 1'b0;
        end else begin
            if (a_req && b_req)
                e_b_win = (m_prev_locked && m_run < int'(MB)) ? m_last : !m_last;
            else
                e_b_win = b_req;
            e_gnt  = a_req || b_req;
            e_we   = e_gnt && (e_b_win ? b_we : a_we);
            e_addr = e_gnt ? (e_b_win ? b_addr : a_addr) : AW'(0);
            e_data = e_gnt ? (e_b_win ? b_wdata : a_wdata) : DW'(0);

            chk("a_gnt", 32'(a_gnt), 32'(e_gnt && !e_b_win));
            chk("b_gnt", 32'(b_gnt), 32'(e_gnt && e_b_win));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_data", 32'(ram_data), 32'(e_data));
            chk("a_rvalid", 32'(a_rvalid), 32'(m_rv_a));
            chk("b_rvalid", 32'(b_rvalid), 32'(m_rv_b));
            if (m_rv_a || m_rv_b) chk("rdata", 32'(rdata), 32'(m_rd));
            chk("burst_cnt", 32'(dut.burst_cnt), 32'(m_run));

            m_rv_a = e_gnt && !e_b_win && !a_we;
            m_rv_b = e_gnt && e_b_win && !b_we;
            if (e_gnt && !e_we) m_rd = shadow[e_addr];
            if (e_gnt) begin
                if (e_we) shadow[e_addr] = e_data;
                if (m_prev_locked && e_b_win == m_last)
                    m_run = (m_run >= 255) ? 255 : m_run + 1;
                else
                    m_run = 1;
                m_prev_locked = e_b_win ? b_lock : a_lock;
                m_last        = e_b_win;
            end else begin
                m_run         = 0;
                m_prev_locked = 1'b0;
            end
        end
        s_a_gnt = a_gnt;  s_b_gnt = b_gnt;
        s_a_rv  = a_rvalid; s_b_rv = b_rvalid;
        s_we    = ram_we; s_addr = ram_addr;
        s_rdata = rdata;  s_cnt  = dut.burst_cnt;
    end

    task automatic cyc(input logic ar, input logic al, input logic aw,
                       input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic br, input logic bl, input logic bw,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_req = ar; a_lock = al; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_lock = bl; b_we = bw; b_addr = ba; b_wdata = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = DW'(i * 7 + 3);
            shadow[i] = DW'(i * 7 + 3);
        end
        rst_n = 1'b0;
        a_req = 1; b_req = 1; a_lock = 1; b_lock = 0; a_we = 1; b_we = 1;
        a_addr = 8'h33; b_addr = 8'h34; a_wdata = 8'h44; b_wdata = 8'h45;
        repeat (2) @(posedge clk);
        #1;
        chk("pin_rst_gnt", 32'({s_a_gnt, s_b_gnt}), 32'd0);
        chk("pin_rst_we", 32'(s_we), 32'd0);
        chk("pin_rst_addr", 32'(s_addr), 32'd0);
        rst_n = 1'b1;

        // Unlocked tie: strict alternation starting with A, rvalid one cycle behind.
        cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        chk("pin_alt1", 32'({s_a_gnt, s_b_gnt}), 32'b10);
        cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        chk("pin_alt2", 32'({s_a_gnt, s_b_gnt}), 32'b01);
        chk("pin_alt2_rv", 32'({s_a_rv, s_b_rv}), 32'b10);
        chk("pin_alt2_rdata", 32'(s_rdata), 32'h0A);
        cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        chk("pin_alt3", 32'({s_a_gnt, s_b_gnt}), 32'b10);
        chk("pin_alt3_rv", 32'({s_a_rv, s_b_rv}), 32'b01);
        cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        chk("pin_alt4", 32'({s_a_gnt, s_b_gnt}), 32'b01);

        // Write then read-after-write from the other requester.
        cyc(1, 0, 1, 8'h10, 8'h5A, 0, 0, 0, 8'h00, 8'h00);
        chk("pin_wr_we", 32'({s_a_gnt, s_we}), 32'b11);
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00);
        chk("pin_raw_gnt", 32'(s_b_gnt), 32'd1);
        idle();
        chk("pin_raw_rv", 32'(s_b_rv), 32'd1);
        chk("pin_raw_rdata", 32'(s_rdata), 32'h5A);

        // Locked burst by A is capped at four grants while B waits.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 0, 8'h05, 8'h00, 1, 0, 0, 8'h06, 8'h00);
            chk("pin_burst", 32'({s_a_gnt, s_b_gnt}), (i == 4) ? 32'b01 : 32'b10);
        end
        idle();

        // Owner drops req mid-lock: B gets the same cycle, run restarts at 1.
        cyc(1, 1, 0, 8'h07, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        cyc(1, 1, 0, 8'h07, 8'h00, 1, 0, 0, 8'h08, 8'h00);
        chk("pin_lock_a", 32'(s_a_gnt), 32'd1);
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h08, 8'h00);
        chk("pin_drop_b", 32'({s_a_gnt, s_b_gnt}), 32'b01);
        chk("pin_drop_cnt2", 32'(s_cnt), 32'd2);
        idle();
        chk("pin_drop_cnt1", 32'(s_cnt), 32'd1);

        // Lone B write is granted immediately; idle returns the RAM port to zero.
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h20, 8'h77);
        chk("pin_bw", 32'({s_b_gnt, s_we, s_addr}), 32'({1'b1, 1'b1, 8'h20}));
        idle();
        chk("pin_bw_idle", 32'({s_we, s_addr}), 32'd0);
        idle();
        chk("pin_idle_cnt", 32'(s_cnt), 32'd0);

        // Lone locked requester runs the counter into saturation.
        for (int i = 0; i < 260; i++) cyc(1, 1, 0, 8'h09, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        cyc(1, 0, 0, 8'h09, 8'h00, 1, 0, 0, 8'h0A, 8'h00);
        chk("pin_sat_cnt", 32'(s_cnt), 32'd255);
        chk("pin_sat_b", 32'(s_b_gnt), 32'd1);

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 48; i++) begin
            automatic logic [7:0] k = 8'(i * 37 + 11);
            cyc(k[0] | k[3], k[1], k[2], k, ~k, k[4] | k[5], k[6], k[7], 8'(k + 1), 8'(k ^ 8'h3C));
        end
        idle();

        // Reset mid-read kills the pending strobe and the tie order.
        cyc(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        chk("pin_pre_rst_rv", 32'(a_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("pin_async_rv", 32'({a_rvalid, b_rvalid}), 32'd0);
        cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        chk("pin_rst_hold", 32'({s_a_gnt, s_b_gnt, s_a_rv, s_b_rv}), 32'd0);
        cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        rst_n = 1'b1;
        cyc(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        chk("pin_post_rst_tie", 32'({s_a_gnt, s_b_gnt}), 32'b10);
        chk("pin_post_rst_rv", 32'({s_a_rv, s_b_rv}), 32'd0);
        idle();
        chk("pin_post_rst_arv", 32'(s_a_rv), 32'd1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
